// File: rtl/parity_frame_accum_pkg.sv
// ============================================================================
// Module      : parity_frame_accum_pkg
// Description : Shared state encoding and width helper for parity_frame_accum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package parity_frame_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } pfa_state_e;

    function automatic int pfa_len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pfa_sat_counter.sv
// ============================================================================
// Module      : pfa_sat_counter
// Description : Saturating beat counter with clear and sticky overflow; exposes
//               the post-update count and overflow for same-edge capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pfa_sat_counter #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [LEN_W-1:0] o_len_next,
    output logic             o_ovf_next
);

    localparam logic [LEN_W-1:0] c_max = LEN_W'(MAX_LEN);

    logic [LEN_W-1:0] r_len;
    logic             r_ovf;
    logic             w_at_max;

    // r_len never exceeds c_max, so equality is the saturation test
    assign w_at_max = (r_len == c_max);

    always_comb begin
        o_len_next = r_len;
        o_ovf_next = r_ovf;
        if (i_clr) begin
            o_len_next = '0;
            o_ovf_next = 1'b0;
        end else if (i_inc) begin
            if (w_at_max) begin
                o_ovf_next = 1'b1;
            end else begin
                o_len_next = r_len + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_len <= o_len_next;
            r_ovf <= o_ovf_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/parity_frame_accum.sv
// ============================================================================
// Module      : parity_frame_accum
// Description : Accumulates per-beat parity bits over a valid/ready framed
//               stream into one frame-parity result with length and overflow.
//               Optional expected-parity check: PARITY_FRAME_ACCUM_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_frame_accum
    import parity_frame_accum_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = pfa_len_w(MAX_LEN),
    parameter bit ODD     = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic [LEN_W-1:0] out_len,
    output logic             out_overflow
`ifdef PARITY_FRAME_ACCUM_CHECK_EN
    ,
    input  logic             exp_parity,
    output logic             out_mismatch
`endif
);

    pfa_state_e       r_state;
    pfa_state_e       w_state_next;
    logic             r_acc;
    logic             w_acc_next;
    logic             w_accept;
    logic             w_handshake;
    logic [LEN_W-1:0] w_len_next;
    logic             w_ovf_next;

    assign in_ready    = (r_state != HOLD);
    assign w_accept    = in_valid && in_ready;
    assign w_handshake = (r_state == HOLD) && out_valid && out_ready;
    assign w_acc_next  = r_acc ^ in_bit;

    pfa_sat_counter #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_len_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_handshake),
        .i_inc      (w_accept),
        .o_len_next (w_len_next),
        .o_ovf_next (w_ovf_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, ACCUM: begin
                if (w_accept) begin
                    w_state_next = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (w_handshake) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= ODD;
        end else if (w_handshake) begin
            r_acc <= ODD;
        end else if (w_accept) begin
            r_acc <= w_acc_next;
        end
    end

    // Result fields capture post-update values so the last beat is included
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_parity   <= 1'b0;
            out_len      <= '0;
            out_overflow <= 1'b0;
        end else if (w_accept && in_last) begin
            out_valid    <= 1'b1;
            out_parity   <= w_acc_next;
            out_len      <= w_len_next;
            out_overflow <= w_ovf_next;
        end else if (w_handshake) begin
            out_valid    <= 1'b0;
        end
    end

`ifdef PARITY_FRAME_ACCUM_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_mismatch <= 1'b0;
        end else if (w_accept && in_last) begin
            out_mismatch <= (w_acc_next != exp_parity);
        end else if (w_handshake) begin
            out_mismatch <= 1'b0;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_parity_frame_accum.sv
// ============================================================================
// Module      : tb_parity_frame_accum
// Description : Self-checking bench; two instances (MAX_LEN=4/ODD=0 and
//               MAX_LEN=16/ODD=1) share one stimulus stream and one frame model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parity_frame_accum;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic       exp_parity = 1'b0;

    logic       rdy_a, vld_a, par_a, ovf_a;
    logic [2:0] len_a;
    logic       rdy_b, vld_b, par_b, ovf_b;
    logic [4:0] len_b;
`ifdef PARITY_FRAME_ACCUM_CHECK_EN
    logic       mm_a, mm_b;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: bits of the frame in progress plus the pending result
    int   q[$];
    bit   m_hold = 1'b0;
    int   e_par_a, e_len_a, e_ovf_a, e_mm_a;
    int   e_par_b, e_len_b, e_ovf_b, e_mm_b;

    always #5 clk = ~clk;

    parity_frame_accum #(.MAX_LEN(4), .ODD(1'b0)) u_dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (rdy_a),
        .in_bit       (in_bit),
        .in_last      (in_last),
        .out_valid    (vld_a),
        .out_ready    (out_ready),
        .out_parity   (par_a),
        .out_len      (len_a),
        .out_overflow (ovf_a)
`ifdef PARITY_FRAME_ACCUM_CHECK_EN
        ,
        .exp_parity   (exp_parity),
        .out_mismatch (mm_a)
`endif
    );

    parity_frame_accum #(.MAX_LEN(16), .ODD(1'b1)) u_dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (rdy_b),
        .in_bit       (in_bit),
        .in_last      (in_last),
        .out_valid    (vld_b),
        .out_ready    (out_ready),
        .out_parity   (par_b),
        .out_len      (len_b),
        .out_overflow (ovf_b)
`ifdef PARITY_FRAME_ACCUM_CHECK_EN
        ,
        .exp_parity   (exp_parity),
        .out_mismatch (mm_b)
`endif
    );

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic frame_result(input int max_len, input int seed, input bit ep,
                                output int par, output int len, output int ovf,
                                output int mm);
        par = seed;
        foreach (q[i]) par = par ^ q[i];
        len = (q.size() > max_len) ? max_len : q.size();
        ovf = (q.size() > max_len) ? 1 : 0;
        mm  = (par != int'(ep)) ? 1 : 0;
    endtask

    // One clock: drive inputs, check at negedge, advance the model after posedge
    task automatic cycle(input bit v, input bit bt, input bit l, input bit r, input bit ep);
        bit acc, hs;
        in_valid   = v;
        in_bit     = bt;
        in_last    = l;
        out_ready  = r;
        exp_parity = ep;
        @(negedge clk);
        chk("in_ready_a", int'(rdy_a), int'(!m_hold));
        chk("in_ready_b", int'(rdy_b), int'(!m_hold));
        chk("out_valid_a", int'(vld_a), int'(m_hold));
        chk("out_valid_b", int'(vld_b), int'(m_hold));
        if (m_hold) begin
            chk("parity_a", int'(par_a), e_par_a);
            chk("len_a", int'(len_a), e_len_a);
            chk("overflow_a", int'(ovf_a), e_ovf_a);
            chk("parity_b", int'(par_b), e_par_b);
            chk("len_b", int'(len_b), e_len_b);
            chk("overflow_b", int'(ovf_b), e_ovf_b);
`ifdef PARITY_FRAME_ACCUM_CHECK_EN
            chk("mismatch_a", int'(mm_a), e_mm_a);
            chk("mismatch_b", int'(mm_b), e_mm_b);
`endif
        end
        acc = v && !m_hold;
        hs  = m_hold && r;
        @(posedge clk);
        #1;
        if (hs) m_hold = 1'b0;
        if (acc) begin
            q.push_back(int'(bt));
            if (l) begin
                frame_result(4, 0, ep, e_par_a, e_len_a, e_ovf_a, e_mm_a);
                frame_result(16, 1, ep, e_par_b, e_len_b, e_ovf_b, e_mm_b);
                m_hold = 1'b1;
                q.delete();
            end
        end
    endtask

    // Assert reset with random inputs for n cycles; release after a posedge
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid   = 1'($urandom);
            in_bit     = 1'($urandom);
            in_last    = 1'($urandom);
            out_ready  = 1'($urandom);
            exp_parity = 1'($urandom);
            @(negedge clk);
            chk("rst_out_valid_a", int'(vld_a), 0);
            chk("rst_parity_a", int'(par_a), 0);
            chk("rst_len_a", int'(len_a), 0);
            chk("rst_overflow_a", int'(ovf_a), 0);
            chk("rst_in_ready_a", int'(rdy_a), 1);
            chk("rst_out_valid_b", int'(vld_b), 0);
            chk("rst_parity_b", int'(par_b), 0);
            chk("rst_len_b", int'(len_b), 0);
            chk("rst_in_ready_b", int'(rdy_b), 1);
`ifdef PARITY_FRAME_ACCUM_CHECK_EN
            chk("rst_mismatch_a", int'(mm_a), 0);
            chk("rst_mismatch_b", int'(mm_b), 0);
`endif
            @(posedge clk);
            #1;
        end
        rst_n  = 1'b1;
        m_hold = 1'b0;
        q.delete();
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset(3);

        // Basic frame 1,0,1,1 with out_ready held high
        cycle(1, 1, 0, 1, 0);
        cycle(1, 0, 0, 1, 0);
        cycle(1, 1, 0, 1, 0);
        cycle(1, 1, 1, 1, 1);
        cycle(0, 0, 0, 1, 0);
        chk("basic_par_a", e_par_a, 1);

        // Backpressure: result held for 5 cycles while in_valid is asserted
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 1, 0, 1);
        for (int i = 0; i < 5; i++) cycle(1, 1, 1, 0, 0);
        cycle(1, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);

        // Overflow on the MAX_LEN=4 instance, then a clean frame
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 1, 0);
        cycle(1, 1, 1, 1, 0);
        cycle(0, 0, 0, 1, 0);
        chk("ovf_frame_flag_a", e_ovf_a, 1);
        cycle(1, 1, 0, 1, 0);
        cycle(1, 0, 1, 1, 1);
        cycle(0, 0, 0, 1, 0);

        // Single-beat frame straight from idle
        cycle(1, 0, 1, 1, 1);
        cycle(0, 0, 0, 1, 0);

        // Reset mid-frame, then frame {1} with expected parity 0
        cycle(1, 1, 0, 1, 0);
        cycle(1, 1, 0, 1, 0);
        do_reset(2);
        cycle(1, 1, 1, 1, 0);
        cycle(0, 0, 0, 1, 0);

        // Reset while a result is held
        cycle(1, 1, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        do_reset(1);
        cycle(1, 0, 1, 1, 0);
        cycle(0, 0, 0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 2) != 0), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
